// File: rtl/fpmul_pkg.sv
// Shared types and constants for the pipelined floating-point multiplier.
// Build option FPMUL_FLAGS_EN adds the {invalid,overflow,underflow,inexact} flag path.
package fpmul_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_class_e;

  localparam int FLAG_INEXACT   = 0;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_W         = 4;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: positive sign, all-ones exponent, only the top mantissa bit set.
  function automatic logic [127:0] qnan(input int exp_w, input int man_w);
    logic [127:0] q;
    q = '0;
    for (int i = 0; i < exp_w; i++) begin
      q = q | (128'd1 << (man_w + i));
    end
    q = q | (128'd1 << (man_w - 1));
    return q;
  endfunction

endpackage

// File: rtl/fpmul_hs_slice.sv
// One pipeline register with valid/ready flow control; payload width is a parameter.
// Handshake: a beat moves when valid and ready are both high on a rising edge;
// up_ready = ~dn_valid | dn_ready, so a full slice accepts only while it is draining.
module fpmul_hs_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);

  assign up_ready = ~dn_valid | dn_ready;

  // Data is captured only on a real transfer so it stays frozen through stalls and bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) begin
        dn_data <= up_data;
      end
    end
  end

endmodule

// File: rtl/fpmul_pipe_hs.sv
// Four-stage floating-point multiplier (unpack, multiply, normalise/round, pack) with
// valid/ready back-pressure and a pass-through tag. FPMUL_FLAGS_EN adds out_flags.
module fpmul_pipe_hs
  import fpmul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_a,
  input  logic [EXP_W+MAN_W:0]     in_b,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_z,
  output logic [TAG_W-1:0]         out_tag
`ifdef FPMUL_FLAGS_EN
  ,
  output logic [FLAG_W-1:0]        out_flags
`endif
);

  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int SIG_W  = MAN_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int XW     = EXP_W + 2;

  localparam logic signed [XW-1:0] BIAS_X    = XW'(bias(EXP_W));
  localparam logic signed [XW-1:0] MAX_X     = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] ZERO_X    = '0;
  localparam logic [127:0]         QNAN_FULL = qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]         QNAN_Z    = QNAN_FULL[W-1:0];

  typedef struct packed {
    logic [TAG_W-1:0]        tag;
    logic                    sign;
    logic                    special;
    logic [W-1:0]            special_z;
    logic signed [XW-1:0]    exp;
    logic [SIG_W-1:0]        sig_a;
    logic [SIG_W-1:0]        sig_b;
`ifdef FPMUL_FLAGS_EN
    logic                    invalid;
`endif
  } s1_t;

  typedef struct packed {
    logic [TAG_W-1:0]        tag;
    logic                    sign;
    logic                    special;
    logic [W-1:0]            special_z;
    logic signed [XW-1:0]    exp;
    logic [PROD_W-1:0]       prod;
`ifdef FPMUL_FLAGS_EN
    logic                    invalid;
`endif
  } s2_t;

  typedef struct packed {
    logic [TAG_W-1:0]        tag;
    logic                    sign;
    logic                    special;
    logic [W-1:0]            special_z;
    logic signed [XW-1:0]    exp;
    logic [MAN_W-1:0]        man;
`ifdef FPMUL_FLAGS_EN
    logic                    lost;
    logic                    invalid;
`endif
  } s3_t;

  typedef struct packed {
    logic [TAG_W-1:0]        tag;
    logic [W-1:0]            z;
`ifdef FPMUL_FLAGS_EN
    logic [FLAG_W-1:0]       flags;
`endif
  } s4_t;

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    if (e == '0) return CLS_ZERO;
    if (e == '1) return (m == '0) ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;
  s4_t s4_d, s4_q;
  logic v1, v2, v3;
  logic rdy2, rdy3, rdy4;

  fp_class_e cls_a, cls_b;
  logic      nan_case;

  // Stage 1: unpack and classify. Subnormals land in CLS_ZERO, which is the flush-to-zero.
  assign cls_a    = classify(in_a[W-2 -: EXP_W], in_a[MAN_W-1:0]);
  assign cls_b    = classify(in_b[W-2 -: EXP_W], in_b[MAN_W-1:0]);
  assign nan_case = (cls_a == CLS_NAN) || (cls_b == CLS_NAN) ||
                    (cls_a == CLS_INF && cls_b == CLS_ZERO) ||
                    (cls_a == CLS_ZERO && cls_b == CLS_INF);

  always_comb begin
    s1_d       = '0;
    s1_d.tag   = in_tag;
    s1_d.sign  = in_a[W-1] ^ in_b[W-1];
    s1_d.exp   = $signed({2'b00, in_a[W-2 -: EXP_W]}) + $signed({2'b00, in_b[W-2 -: EXP_W]}) - BIAS_X;
    s1_d.sig_a = {1'b1, in_a[MAN_W-1:0]};
    s1_d.sig_b = {1'b1, in_b[MAN_W-1:0]};
    if (nan_case) begin
      s1_d.special   = 1'b1;
      s1_d.special_z = QNAN_Z;
`ifdef FPMUL_FLAGS_EN
      s1_d.invalid   = 1'b1;
`endif
    end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
      s1_d.special   = 1'b1;
      s1_d.special_z = {s1_d.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
      s1_d.special   = 1'b1;
      s1_d.special_z = {s1_d.sign, {(W-1){1'b0}}};
    end
  end

  fpmul_hs_slice #(.W($bits(s1_t))) u_s1 (
    .clk(clk), .rst(rst),
    .up_valid(in_valid), .up_ready(in_ready), .up_data(s1_d),
    .dn_valid(v1), .dn_ready(rdy2), .dn_data(s1_q)
  );

  // Stage 2: full-width significand product.
  always_comb begin
    s2_d           = '0;
    s2_d.tag       = s1_q.tag;
    s2_d.sign      = s1_q.sign;
    s2_d.special   = s1_q.special;
    s2_d.special_z = s1_q.special_z;
    s2_d.exp       = s1_q.exp;
    s2_d.prod      = PROD_W'(s1_q.sig_a) * PROD_W'(s1_q.sig_b);
`ifdef FPMUL_FLAGS_EN
    s2_d.invalid   = s1_q.invalid;
`endif
  end

  fpmul_hs_slice #(.W($bits(s2_t))) u_s2 (
    .clk(clk), .rst(rst),
    .up_valid(v1), .up_ready(rdy2), .up_data(s2_d),
    .dn_valid(v2), .dn_ready(rdy3), .dn_data(s2_q)
  );

  logic                norm;
  logic [PROD_W-2:0]   frac;
  logic [MAN_W-1:0]    man_t;
  logic                g_bit, r_bit, s_bit, round_up;
  logic [MAN_W:0]      man_rnd;

  // Stage 3: frac is the product left-aligned below the hidden bit, so the mantissa,
  // guard, round and sticky fields sit at fixed positions whichever way it normalised.
  always_comb begin
    norm     = s2_q.prod[PROD_W-1];
    frac     = norm ? s2_q.prod[PROD_W-2:0] : {s2_q.prod[PROD_W-3:0], 1'b0};
    man_t    = frac[2*MAN_W:MAN_W+1];
    g_bit    = frac[MAN_W];
    r_bit    = frac[MAN_W-1];
    s_bit    = |frac[MAN_W-2:0];
    round_up = g_bit & (r_bit | s_bit | man_t[0]);
    man_rnd  = {1'b0, man_t} + {{MAN_W{1'b0}}, round_up};

    s3_d           = '0;
    s3_d.tag       = s2_q.tag;
    s3_d.sign      = s2_q.sign;
    s3_d.special   = s2_q.special;
    s3_d.special_z = s2_q.special_z;
    s3_d.man       = man_rnd[MAN_W-1:0];
    s3_d.exp       = s2_q.exp + $signed({{(XW-1){1'b0}}, norm}) + $signed({{(XW-1){1'b0}}, man_rnd[MAN_W]});
`ifdef FPMUL_FLAGS_EN
    s3_d.lost      = g_bit | r_bit | s_bit;
    s3_d.invalid   = s2_q.invalid;
`endif
  end

  fpmul_hs_slice #(.W($bits(s3_t))) u_s3 (
    .clk(clk), .rst(rst),
    .up_valid(v2), .up_ready(rdy3), .up_data(s3_d),
    .dn_valid(v3), .dn_ready(rdy4), .dn_data(s3_q)
  );

  logic ovf, unf;

  // Stage 4: exponent range check and final pack.
  always_comb begin
    ovf    = $signed(s3_q.exp) >= MAX_X;
    unf    = $signed(s3_q.exp) <= ZERO_X;
    s4_d     = '0;
    s4_d.tag = s3_q.tag;
    if (s3_q.special) begin
      s4_d.z = s3_q.special_z;
    end else if (ovf) begin
      s4_d.z = {s3_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (unf) begin
      s4_d.z = {s3_q.sign, {(W-1){1'b0}}};
    end else begin
      s4_d.z = {s3_q.sign, s3_q.exp[EXP_W-1:0], s3_q.man};
    end
`ifdef FPMUL_FLAGS_EN
    s4_d.flags[FLAG_INVALID]   = s3_q.invalid;
    s4_d.flags[FLAG_OVERFLOW]  = ~s3_q.special & ovf;
    s4_d.flags[FLAG_UNDERFLOW] = ~s3_q.special & unf;
    s4_d.flags[FLAG_INEXACT]   = ~s3_q.special & (s3_q.lost | ovf | unf);
`endif
  end

  fpmul_hs_slice #(.W($bits(s4_t))) u_s4 (
    .clk(clk), .rst(rst),
    .up_valid(v3), .up_ready(rdy4), .up_data(s4_d),
    .dn_valid(out_valid), .dn_ready(out_ready), .dn_data(s4_q)
  );

  assign out_z   = s4_q.z;
  assign out_tag = s4_q.tag;
`ifdef FPMUL_FLAGS_EN
  assign out_flags = s4_q.flags;
`endif

endmodule
